// File: rtl/pixel_pkg.sv
// Shared types for the pixel window buffer: pixel width, window layout and FSM states.
package pixel_pkg;

    localparam int PIX_W = 4;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t window_t [3][3];

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

endpackage

// File: rtl/pixel_window_buffer_line_buffer.sv
// One raster line of pixels: asynchronous read and synchronous write at a shared address.
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int PIX_W = 4
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     wr_en,
    input  logic [PIX_W-1:0]         wr_data,
    output logic [PIX_W-1:0]         rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Combinational read so the new window column is formed in the accepting cycle.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/pixel_window_buffer.sv
// Raster pixel stream to 3x3 neighbourhood windows, with position tracking and frame-done pulse.
//
// state    | meaning
// WAIT_SOF | idle; only a valid pixel with frameStart is accepted (as pixel 0,0)
// ACTIVE   | accepting pixels of a frame; frameStart here restarts the frame
module pixel_window_buffer #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int PIX_W      = pixel_pkg::PIX_W
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic [PIX_W-1:0]              pixelIn,
    input  logic                          pixelInValid,
    input  logic                          frameStart,
    output logic [PIX_W-1:0]              window [3][3],
    output logic                          windowValid,
    output logic [$clog2(IMG_WIDTH)-1:0]  centerX,
    output logic [$clog2(IMG_HEIGHT)-1:0] centerY,
    output logic                          frameDone
);

    import pixel_pkg::*;

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t           state, state_next;
    logic [CW-1:0]    col, col_next, col_cur;
    logic [RW-1:0]    row, row_next, row_cur;
    logic             accept;
    logic             last_pix;
    logic             win_ok;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [PIX_W-1:0] new_col [3];

    // A frameStart pixel is always position (0,0), even when it aborts a frame in progress.
    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        accept     = 1'b0;
        col_cur    = col;
        row_cur    = row;
        if (pixelInValid && (frameStart || state == ACTIVE)) begin
            accept = 1'b1;
            if (frameStart) begin
                col_cur = '0;
                row_cur = '0;
            end
        end
        last_pix = (col_cur == COL_LAST) && (row_cur == ROW_LAST);
        win_ok   = accept && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
        if (accept) begin
            state_next = ACTIVE;
            if (last_pix) begin
                state_next = WAIT_SOF;
                col_next   = '0;
                row_next   = '0;
            end else if (col_cur == COL_LAST) begin
                col_next = '0;
                row_next = row_cur + 1'b1;
            end else begin
                col_next = col_cur + 1'b1;
                row_next = row_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= WAIT_SOF;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
        end
    end

    line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb0 (
        .clk     (clk),
        .addr    (col_cur),
        .wr_en   (accept),
        .wr_data (pixelIn),
        .rd_data (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
        .clk     (clk),
        .addr    (col_cur),
        .wr_en   (accept),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    assign new_col[0] = lb1_rd;
    assign new_col[1] = lb0_rd;
    assign new_col[2] = pixelIn;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    window[r][c] <= '0;
                end
            end
            windowValid <= 1'b0;
            frameDone   <= 1'b0;
            centerX     <= '0;
            centerY     <= '0;
        end else begin
            windowValid <= win_ok;
            frameDone   <= win_ok && last_pix;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    window[r][0] <= window[r][1];
                    window[r][1] <= window[r][2];
                    window[r][2] <= new_col[r];
                end
                centerX <= col_cur - 1'b1;
                centerY <= row_cur - 1'b1;
            end
        end
    end

endmodule
